// File: rtl/raster_stamp_csr_pkg.sv
// Shared types, CSR map and packing helper for the raster stamp CSR responder.
package raster_stamp_csr_pkg;

   localparam int unsigned RASTER_DIM_BITS      = 12;
   localparam int unsigned RASTER_PID_BITS      = 4;
   localparam int unsigned RASTER_POS_MASK_BITS = 2 * (RASTER_DIM_BITS - 1) + 4;
   localparam int unsigned CSR_ADDR_BITS        = 12;

   localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_POS_MASK     = 12'h7C0;
   localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X0    = 12'h7C1;
   localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y0    = 12'h7C5;
   localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z0    = 12'h7C9;
   localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_COUNT = 12'd12;

   typedef struct packed {
      logic [RASTER_PID_BITS-1:0] pid;
      logic [3:0][31:0]           bcoord_z;
      logic [3:0][31:0]           bcoord_y;
      logic [3:0][31:0]           bcoord_x;
      logic [RASTER_DIM_BITS-2:0] pos_y;
      logic [RASTER_DIM_BITS-2:0] pos_x;
      logic [3:0]                 mask;
   } raster_stamp_t;

   typedef struct packed {
      logic [31:0]      pos_mask;
      logic [3:0][31:0] bcoord_z;
      logic [3:0][31:0] bcoord_y;
      logic [3:0][31:0] bcoord_x;
   } raster_csrs_t;

   typedef enum logic {StIdle, StRsp} rsp_state_e;

   function automatic logic [31:0] raster_pos_mask(raster_stamp_t stamp);
      return 32'({stamp.pos_y, stamp.pos_x, stamp.mask});
   endfunction

endpackage

// File: rtl/raster_stamp_csr_if.sv
// Stamp stream plus CSR request/response bus for the raster stamp responder.
interface raster_stamp_csr_if;
   import raster_stamp_csr_pkg::*;

   logic                     stamp_valid;
   raster_stamp_t            stamp_data;
   logic                     stamp_ready;
   logic                     raster_done;
   logic                     csr_req_valid;
   logic [CSR_ADDR_BITS-1:0] csr_req_addr;
   logic                     csr_req_ready;
   logic                     csr_rsp_valid;
   logic [31:0]              csr_rsp_data;
   logic                     csr_rsp_ready;
   logic                     queue_empty;

   modport master (
      output stamp_valid, stamp_data, raster_done, csr_req_valid, csr_req_addr, csr_rsp_ready,
      input  stamp_ready, csr_req_ready, csr_rsp_valid, csr_rsp_data, queue_empty
   );

   modport slave (
      input  stamp_valid, stamp_data, raster_done, csr_req_valid, csr_req_addr, csr_rsp_ready,
      output stamp_ready, csr_req_ready, csr_rsp_valid, csr_rsp_data, queue_empty
   );

endinterface

// File: rtl/raster_stamp_csr_fifo.sv
// Generic registered FIFO; a pushed entry becomes visible at the head the next cycle.
module raster_stamp_csr_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AddrBits = $clog2(Depth);

   logic [Width-1:0]  mem_q [Depth];
   logic [AddrBits:0] wr_ptr_q, rd_ptr_q;
   logic              do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrBits] != rd_ptr_q[AddrBits]) &&
                    (wr_ptr_q[AddrBits-1:0] == rd_ptr_q[AddrBits-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q[AddrBits-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AddrBits-1:0]] <= data_i;
   end

endmodule

// File: rtl/raster_stamp_csr.sv
// Raster stamp CSR responder: buffers stamps and serves POS_MASK / BCOORD CSR reads
// through a single registered response slot.
module raster_stamp_csr
   import raster_stamp_csr_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   raster_stamp_csr_if.slave bus
);

   if (RASTER_POS_MASK_BITS > 32) begin : g_pos_mask_chk
      $error("pos_mask packing does not fit in 32 bits");
   end
   if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("QUEUE_DEPTH must be a power of two and at least 2");
   end

   raster_stamp_t            head;
   logic                     fifo_empty, fifo_full, pop;
   logic                     is_pos, slot_free, accept, bc_hit;
   logic [CSR_ADDR_BITS-1:0] bc_idx;
   rsp_state_e               state_q, state_d;
   logic [31:0]              rsp_data_q, rsp_data_d;
   raster_csrs_t             cur_q, cur_d;

   raster_stamp_csr_fifo #(
      .Width ($bits(raster_stamp_t)),
      .Depth (QUEUE_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.stamp_valid),
      .pop_i   (pop),
      .data_i  (bus.stamp_data),
      .data_o  (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign bus.stamp_ready   = !fifo_full;
   assign bus.queue_empty   = fifo_empty;
   assign bus.csr_rsp_valid = (state_q == StRsp);
   assign bus.csr_rsp_data  = rsp_data_q;

   // A POS_MASK read with nothing queued stalls until a stamp lands or the pass ends.
   assign is_pos            = (bus.csr_req_addr == CSR_RASTER_POS_MASK);
   assign slot_free         = (state_q == StIdle) || bus.csr_rsp_ready;
   assign bus.csr_req_ready = slot_free && !(is_pos && fifo_empty && !bus.raster_done);
   assign accept            = bus.csr_req_valid && bus.csr_req_ready;

   assign bc_idx = bus.csr_req_addr - CSR_RASTER_BCOORD_X0;
   assign bc_hit = (bc_idx < CSR_RASTER_BCOORD_COUNT);

   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      cur_d      = cur_q;
      pop        = 1'b0;

      unique case (state_q)
         StIdle: if (accept) state_d = StRsp;
         StRsp:  if (!accept && bus.csr_rsp_ready) state_d = StIdle;
      endcase

      if (accept) begin
         rsp_data_d = '0;
         if (is_pos) begin
            if (!fifo_empty) begin
               pop            = 1'b1;
               cur_d.pos_mask = raster_pos_mask(head);
               cur_d.bcoord_x = head.bcoord_x;
               cur_d.bcoord_y = head.bcoord_y;
               cur_d.bcoord_z = head.bcoord_z;
               rsp_data_d     = raster_pos_mask(head);
            end else begin
               cur_d = '0;
            end
         end else if (bc_hit) begin
            case (bc_idx[3:2])
               2'd0:    rsp_data_d = cur_q.bcoord_x[bc_idx[1:0]];
               2'd1:    rsp_data_d = cur_q.bcoord_y[bc_idx[1:0]];
               default: rsp_data_d = cur_q.bcoord_z[bc_idx[1:0]];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rsp_data_q <= '0;
         cur_q      <= '0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         cur_q      <= cur_d;
      end
   end

endmodule

// File: tb/tb_raster_stamp_csr.sv
// Directed bench for raster_stamp_csr with a queue-based response scoreboard.
module tb_raster_stamp_csr;
   import raster_stamp_csr_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   raster_stamp_csr_if bus ();

   raster_stamp_csr #(
      .QUEUE_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected POS_MASK packing: pos_y at [25:15], pos_x at [14:4], mask at [3:0].
   function automatic logic [31:0] pm(input int px, input int py, input logic [3:0] m);
      return 32'((py << 15) | (px << 4) | int'(m));
   endfunction

   function automatic raster_stamp_t mk(input int px, input int py, input logic [3:0] m,
                                        input logic [7:0] tag);
      raster_stamp_t s;
      s.pid   = tag[3:0];
      s.pos_x = 11'(px);
      s.pos_y = 11'(py);
      s.mask  = m;
      for (int i = 0; i < 4; i++) begin
         s.bcoord_x[i] = {4'h1, 12'h0, tag, 4'(i), 4'h0};
         s.bcoord_y[i] = {4'h2, 12'h0, tag, 4'(i), 4'h0};
         s.bcoord_z[i] = {4'h3, 12'h0, tag, 4'(i), 4'h0};
      end
      return s;
   endfunction

   // Monitor: every response handshake pops and compares one expected value.
   always @(negedge clk) begin
      if (reset && bus.csr_rsp_valid && bus.csr_rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got 0x%08h expected none", bus.csr_rsp_data);
         end else begin
            check("rsp_data", bus.csr_rsp_data, exp_q.pop_front());
         end
      end
   end

   task automatic push_stamp(input raster_stamp_t s);
      int n;
      bus.stamp_valid = 1'b1;
      bus.stamp_data  = s;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.stamp_ready) break;
      end
      if (n == 200) check("push_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk);
         #1;
      end
      bus.stamp_valid = 1'b0;
   endtask

   task automatic read(input logic [CSR_ADDR_BITS-1:0] addr, input logic [31:0] exp);
      int n;
      exp_q.push_back(exp);
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = addr;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.csr_req_ready) break;
      end
      if (n == 200) begin
         check("req_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_back());
      end else begin
         @(posedge clk);
         #1;
      end
      bus.csr_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      for (n = 0; n < 200; n++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (n == 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      raster_stamp_t s;
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      raster_stamp_t s;
      bus.stamp_valid   = 1'b0;
      bus.stamp_data    = '0;
      bus.raster_done   = 1'b0;
      bus.csr_req_valid = 1'b0;
      bus.csr_req_addr  = '0;
      bus.csr_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_stamp_ready", 32'(bus.stamp_ready), 32'd1);
      check("rst_queue_empty", 32'(bus.queue_empty), 32'd1);
      check("rst_rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
      check("rst_rsp_data", bus.csr_rsp_data, 32'd0);
      @(posedge clk);
      #1;

      // Basic fetch
      s = mk(3, 5, 4'hB, 8'h01);
      s.bcoord_x[2] = 32'h3F00_0000;
      push_stamp(s);
      read(CSR_RASTER_POS_MASK, 32'h0002_803B);
      read(CSR_RASTER_BCOORD_X0 + 12'd2, 32'h3F00_0000);
      wait_drain();

      // Fill and backpressure
      bus.csr_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_stamp(mk(10 + i, 20 + i, 4'(i + 1), 8'h10 + 8'(i)));
      @(negedge clk);
      check("full_stamp_ready", 32'(bus.stamp_ready), 32'd0);
      check("full_queue_empty", 32'(bus.queue_empty), 32'd0);
      @(posedge clk);
      #1;
      bus.stamp_valid = 1'b1;
      bus.stamp_data  = mk(14, 24, 4'd5, 8'h14);
      exp_q.push_back(pm(10, 20, 4'd1));
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = CSR_RASTER_POS_MASK;
      @(negedge clk);
      check("fill_req_ready", 32'(bus.csr_req_ready), 32'd1);
      check("fill_ready_not_comb", 32'(bus.stamp_ready), 32'd0);
      @(posedge clk);
      #1 bus.csr_req_valid = 1'b0;
      @(negedge clk);
      check("pop_frees_slot", 32'(bus.stamp_ready), 32'd1);
      @(posedge clk);
      #1 bus.stamp_valid = 1'b0;
      bus.csr_rsp_ready = 1'b1;
      for (int i = 1; i < 5; i++) read(CSR_RASTER_POS_MASK, pm(10 + i, 20 + i, 4'(i + 1)));
      wait_drain();

      // Empty stall
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = CSR_RASTER_POS_MASK;
      exp_q.push_back(pm(30, 40, 4'h6));
      repeat (3) begin
         @(negedge clk);
         check("stall_req_ready", 32'(bus.csr_req_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus.stamp_valid = 1'b1;
      bus.stamp_data = mk(30, 40, 4'h6, 8'h20);
      @(negedge clk);
      check("stall_before_push", 32'(bus.csr_req_ready), 32'd0);
      @(posedge clk);
      #1 bus.stamp_valid = 1'b0;
      @(negedge clk);
      check("stall_release", 32'(bus.csr_req_ready), 32'd1);
      @(posedge clk);
      #1 bus.csr_req_valid = 1'b0;
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
      wait_drain();

      // Done drain
      push_stamp(mk(1, 2, 4'h3, 8'h30));
      push_stamp(mk(7, 9, 4'hC, 8'h31));
      bus.raster_done = 1'b1;
      read(CSR_RASTER_POS_MASK, pm(1, 2, 4'h3));
      read(CSR_RASTER_BCOORD_Y0 + 12'd1, 32'h2000_3010);
      read(CSR_RASTER_POS_MASK, pm(7, 9, 4'hC));
      read(CSR_RASTER_POS_MASK, 32'd0);
      read(CSR_RASTER_BCOORD_Z0, 32'd0);
      wait_drain();
      check("drain_queue_empty", 32'(bus.queue_empty), 32'd1);

      // Response hold
      push_stamp(mk(100, 200, 4'hF, 8'h40));
      bus.csr_rsp_ready = 1'b0;
      read(CSR_RASTER_POS_MASK, pm(100, 200, 4'hF));
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = 12'h123;
      exp_q.push_back(32'd0);
      repeat (3) begin
         @(negedge clk);
         check("hold_rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
         check("hold_rsp_data", bus.csr_rsp_data, pm(100, 200, 4'hF));
         check("hold_req_ready", 32'(bus.csr_req_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus.csr_rsp_ready = 1'b1;
      @(negedge clk);
      check("hold_release_ready", 32'(bus.csr_req_ready), 32'd1);
      @(posedge clk);
      #1 bus.csr_req_valid = 1'b0;
      wait_drain();

      // Async reset
      bus.raster_done = 1'b0;
      push_stamp(mk(50, 60, 4'h9, 8'h50));
      push_stamp(mk(51, 61, 4'hA, 8'h51));
      bus.csr_rsp_ready = 1'b0;
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = CSR_RASTER_POS_MASK;
      @(posedge clk);
      #1 bus.csr_req_valid = 1'b0;
      @(negedge clk);
      check("arst_pending", 32'(bus.csr_rsp_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("arst_rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
      check("arst_rsp_data", bus.csr_rsp_data, 32'd0);
      check("arst_queue_empty", 32'(bus.queue_empty), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      bus.raster_done   = 1'b1;
      bus.csr_rsp_ready = 1'b1;
      read(CSR_RASTER_POS_MASK, 32'd0);
      read(CSR_RASTER_BCOORD_X0, 32'd0);
      wait_drain();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
